// File: rtl/int_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// int_arbiter_pkg
// Shared definitions for the interrupt arbiter: register byte offsets, the
// interrupt-bus codes driven toward the core-local interruptor, and the
// one-hot gateway state encoding.
// -----------------------------------------------------------------------------
package int_arbiter_pkg;

    // Register byte offsets. PRIO[n] lives at ARB_PRIO_BASE + 4*n, n >= 1.
    localparam logic [7:0] ARB_PRIO_BASE = 8'h00;
    localparam logic [7:0] ARB_ENABLE    = 8'h80;
    localparam logic [7:0] ARB_THRESH    = 8'h84;
    localparam logic [7:0] ARB_CLAIM     = 8'h88;
    localparam logic [7:0] ARB_PENDING   = 8'h8C;

    // Interrupt bus codes.
    localparam logic [7:0] INT_NONE = 8'h00;
    localparam logic [7:0] INT_EXT  = 8'h02;

    // Gateway states, one-hot.
    typedef enum logic [2:0] {
        GW_IDLE   = 3'b001,
        GW_PEND   = 3'b010,
        GW_INSERV = 3'b100
    } gw_state_e;

    // Byte address of PRIO[id].
    function automatic logic [7:0] prio_addr(input int id);
        return ARB_PRIO_BASE + 8'(id << 2);
    endfunction

endpackage

// File: rtl/int_gateway.sv
// -----------------------------------------------------------------------------
// int_gateway
// Per-source interrupt gateway: a two-flop synchronizer for the asynchronous
// level line, followed by a three-state request FSM.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   irq      in   raw level interrupt line (asynchronous to clk)
//   claim    in   this source is being claimed this cycle
//   complete in   complete write for this source this cycle
//   pend     out  source is pending
//   inserv   out  source is in service
//
// state     | meaning
// ----------+-----------------------------------------------------------
// GW_IDLE   | no request held; waits for the synchronized line to be high
// GW_PEND   | request latched, visible to arbitration, waiting for a claim
// GW_INSERV | claimed by the handler; line ignored until complete
// -----------------------------------------------------------------------------
module int_gateway
    import int_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic claim,
    input  logic complete,
    output logic pend,
    output logic inserv
);

    logic      sync_ff1;
    logic      sync_ff2;
    gw_state_e state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff1 <= 1'b0;
            sync_ff2 <= 1'b0;
            state    <= GW_IDLE;
        end else begin
            sync_ff1 <= irq;
            sync_ff2 <= sync_ff1;
            case (state)
                GW_IDLE:   if (sync_ff2) state <= GW_PEND;
                GW_PEND:   if (claim)    state <= GW_INSERV;
                // Returning through IDLE means a line still held high
                // re-pends one edge after the complete.
                GW_INSERV: if (complete) state <= GW_IDLE;
                default:                 state <= GW_IDLE;
            endcase
        end
    end

    // Outputs are single bits of the registered one-hot state.
    assign pend   = state[1];
    assign inserv = state[2];

endmodule

// File: rtl/int_arbiter.sv
// -----------------------------------------------------------------------------
// int_arbiter
// Priority interrupt arbiter feeding the core-local interruptor's int_flag.
// Synchronizes and latches NUM_SRC level interrupt lines, picks the highest
// priority enabled pending source above THRESHOLD (ties to the lowest ID),
// and offers a claim/complete register for the trap handler.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   irq_src_i   in   [NUM_SRC]  raw level lines; bit n-1 is source ID n
//   we_i        in   register write strobe
//   waddr_i     in   [8]  write byte address
//   wdata_i     in   [32] write data
//   re_i        in   register read strobe (claim side effect only when high)
//   raddr_i     in   [8]  read byte address
//   rdata_o     out  [32] registered read data, updated on re_i
//   int_flag_o  out  [8]  INT_EXT while a request qualifies, else INT_NONE
// -----------------------------------------------------------------------------
module int_arbiter
    import int_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic               we_i,
    input  logic [7:0]         waddr_i,
    input  logic [31:0]        wdata_i,
    input  logic               re_i,
    input  logic [7:0]         raddr_i,
    output logic [31:0]        rdata_o,
    output logic [7:0]         int_flag_o
);

    // Register file
    logic [PRIO_W-1:0] prio_q [1:NUM_SRC];
    logic [NUM_SRC:1]  enable_q;
    logic [PRIO_W-1:0] thresh_q;

    // Gateway status and per-source strobes
    logic [NUM_SRC:1]  pend;
    logic [NUM_SRC:1]  inserv;
    logic [NUM_SRC:1]  claim_vec;
    logic [NUM_SRC:1]  complete_vec;

    // Arbitration
    logic [4:0]        best_id_d;
    logic [4:0]        best_id_q;
    logic [PRIO_W-1:0] best_prio;
    logic [4:0]        claim_id;
    logic [7:0]        int_flag_q;

    logic [31:0]       rdata_d;
    logic              rd_claim;
    logic              wr_complete;

    // Only a few write-data bits are meaningful at any address.
    logic              unused_wdata;
    assign unused_wdata = ^wdata_i;

    assign rd_claim    = re_i && (raddr_i == ARB_CLAIM);
    assign wr_complete = we_i && (waddr_i == ARB_CLAIM);

    // -------------------------------------------------------------------------
    // Gateways
    // -------------------------------------------------------------------------
    for (genvar g = 1; g <= NUM_SRC; g++) begin : g_gw
        int_gateway u_gw (
            .clk      (clk),
            .rst      (rst),
            .irq      (irq_src_i[g-1]),
            .claim    (claim_vec[g]),
            .complete (complete_vec[g]),
            .pend     (pend[g]),
            .inserv   (inserv[g])
        );
    end

    // -------------------------------------------------------------------------
    // Claim / complete decode
    // The claimed ID is the registered winner, but only while that source is
    // still pending. This keeps a back-to-back claim from returning an ID that
    // the previous claim already moved to service before best_id_q caught up.
    // -------------------------------------------------------------------------
    always_comb begin
        claim_id     = '0;
        claim_vec    = '0;
        complete_vec = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            if ((best_id_q == 5'(i)) && pend[i]) begin
                claim_id = 5'(i);
                if (rd_claim) claim_vec[i] = 1'b1;
            end
            if (wr_complete && (wdata_i[4:0] == 5'(i)) && inserv[i])
                complete_vec[i] = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Priority tree: strict greater-than while scanning upward keeps the
    // lowest ID on a tie. PRIO > THRESHOLD implies PRIO >= 1, so a zero
    // starting best_prio never admits a priority-0 source.
    // -------------------------------------------------------------------------
    always_comb begin
        best_id_d = '0;
        best_prio = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            if (pend[i] && enable_q[i] && (prio_q[i] > thresh_q)
                && (prio_q[i] > best_prio)) begin
                best_id_d = 5'(i);
                best_prio = prio_q[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Register file writes
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i <= NUM_SRC; i++) prio_q[i] <= '0;
            enable_q <= '0;
            thresh_q <= '0;
        end else if (we_i) begin
            for (int i = 1; i <= NUM_SRC; i++) begin
                if (waddr_i == prio_addr(i)) prio_q[i] <= wdata_i[PRIO_W-1:0];
            end
            if (waddr_i == ARB_ENABLE) enable_q <= wdata_i[NUM_SRC:1];
            if (waddr_i == ARB_THRESH) thresh_q <= wdata_i[PRIO_W-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Read mux
    // -------------------------------------------------------------------------
    always_comb begin
        rdata_d = '0;
        case (raddr_i)
            ARB_ENABLE:  rdata_d = 32'({enable_q, 1'b0});
            ARB_THRESH:  rdata_d = 32'(thresh_q);
            ARB_CLAIM:   rdata_d = 32'(claim_id);
            ARB_PENDING: rdata_d = 32'({pend, 1'b0});
            default: begin
                for (int i = 1; i <= NUM_SRC; i++) begin
                    if (raddr_i == prio_addr(i)) rdata_d = 32'(prio_q[i]);
                end
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered outputs. The winner register samples pre-claim gateway state,
    // so int_flag_o drops or moves to the next winner one edge after a claim.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_o    <= '0;
            best_id_q  <= '0;
            int_flag_q <= INT_NONE;
        end else begin
            best_id_q  <= best_id_d;
            int_flag_q <= (best_id_d != 5'd0) ? INT_EXT : INT_NONE;
            if (re_i) rdata_o <= rdata_d;
        end
    end

    assign int_flag_o = int_flag_q;

endmodule

// File: doc/int_arbiter.md
# int_arbiter

Priority interrupt arbiter that sits upstream of the core-local interruptor and drives its `int_flag` input. It collects up to NUM_SRC external level-sensitive interrupt lines and synchronizes and latches them per source. It selects the highest-priority enabled pending source above a threshold, and exposes a claim/complete register interface on the CSR/peripheral bus so the trap handler can identify and retire the request.

## Interface
- NUM_SRC, 8: number of external sources, 1..31; IDs are 1..NUM_SRC, 0 means none.
- PRIO_W, 3: priority width; priority 0 means never interrupt.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- irq_src_i  in  NUM_SRC  raw level interrupt lines, asynchronous to clk.
- we_i  in  1  register write strobe.
- waddr_i  in  8  register write byte address.
- wdata_i  in  32  register write data.
- re_i  in  1  register read strobe; claim side effect only when high.
- raddr_i  in  8  register read byte address.
- rdata_o  out  32  read data, registered.
- int_flag_o  out  8 (`INT_BUS`)  `INT_EXT` (8'h02) while a request qualifies, `INT_NONE` otherwise.

## Operation
- Register map, word-aligned:
  - PRIO[n] at 0x04*n for n=1..NUM_SRC, RW, bits [PRIO_W-1:0].
  - ENABLE at 0x80, RW, bit n enables source n.
  - THRESHOLD at 0x84, RW, [PRIO_W-1:0].
  - CLAIM/COMPLETE at 0x88.
  - PENDING at 0x8C, RO, bit n.
  - Unmapped reads return 0. Unmapped writes are ignored.
- Per-source gateway FSM:
  - IDLE -> PEND when the synchronized source is high.
  - PEND -> INSERV on a claim of that ID.
  - INSERV -> IDLE on a complete write of that ID.
  - A source in INSERV ignores its line. If the line is still high after complete, the source re-pends on the next edge.
- Arbitration, registered every cycle:
  - Candidates are sources in PEND with ENABLE set and PRIO > THRESHOLD.
  - Winner is the highest PRIO. Ties go to the lowest ID.
  - Internal best_id is 0 if there are no candidates.
  - int_flag_o = `INT_EXT` iff best_id != 0.
- Claim (re_i with raddr_i=0x88):
  - rdata_o <= best_id.
  - That source moves PEND -> INSERV at the same edge.
  - If best_id is 0, there is no state change and the read returns 0.
- Complete (we_i with waddr_i=0x88): wdata_i[4:0] = ID.
  - Takes effect only if that source is in INSERV.
  - ID 0, ID > NUM_SRC, or a source not in INSERV: ignored.
- Disabling or lowering the priority of a pending source removes it from arbitration but keeps it in PEND.
- Comparisons are unsigned, PRIO_W bits. IDs are 5 bits, zero-extended on rdata_o.

## Timing
- Reset: rdata_o=0 and int_flag_o=`INT_NONE`. All PRIO, ENABLE and THRESHOLD registers are 0. All gateways are IDLE. Synchronizers are cleared.
- Reset mid-operation: asynchronous. All pending and in-service state is lost immediately, with no complete required.
- Source latency, where edge k is the first edge sampling the source high:
  - sync FF1 at k, FF2 at k+1;
  - PEND at k+2;
  - int_flag_o high after edge k+3.
- Claim at edge c:
  - rdata_o valid after c;
  - the source is no longer a candidate after c;
  - int_flag_o reflects the next winner, or drops, after c+1.
- Register write at edge w affects arbitration from edge w+1. int_flag_o follows after w+1.
- Same-cycle claim and complete on the same address: the claim reads pre-complete state. The complete then applies, so a source completed in that cycle becomes eligible at c+1.
- Claim and a new source rising in the same cycle: the new source does not affect the claimed ID.
- Read latency is 1 cycle for all registers. Reads without re_i have no side effects.

## Structure
- Shared include (`include.v`) holds:
  - register offset defines (`ARB_PRIO_BASE`, `ARB_ENABLE`, `ARB_THRESH`, `ARB_CLAIM`, `ARB_PENDING`);
  - `INT_EXT` alongside the existing `INT_NONE`;
  - gateway state encodings (one-hot, 3 bits).
- Sub-module `int_gateway`: 2-FF synchronizer plus the 3-state FSM. It is instantiated NUM_SRC times and outputs `pend` and `inserv`.
- Top level holds the register file, the priority tree (a combinational loop over sources, registered result) and the read mux.

## Test plan
- Reset, then PRIO[3]=2, ENABLE=0x08, THRESHOLD=0. Raise src3 at edge k -> int_flag_o=8'h02 after k+3. Claim reads 3 and int_flag_o=8'h00 one cycle later.
- src2 (prio 5) and src6 (prio 5) plus src4 (prio 7), all enabled and pending -> claims return 4, then 2, then 6.
- THRESHOLD=5 with src2 at prio 5 pending -> int_flag_o stays 8'h00. Set THRESHOLD=4 -> int_flag_o=8'h02 two cycles after the write.
- src1 claimed, line held high -> no re-pend. Complete ID 1 -> PENDING bit1 set 1 cycle later and int_flag_o asserts again. Complete ID 5 while not in service -> no change.
- Claim with nothing pending -> reads 0 with no state change. Assert rst mid-claim with sources pending -> PENDING=0, int_flag_o=8'h00 immediately, ENABLE=0.
- Same-cycle complete(ID 2) and claim while src2 is re-raised -> claim returns the other winner, and src2 re-pends two edges later.
